// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier / MAC datapath.
// Holds the product width of the 4x4 array multiplier and the state type of
// the accumulate stage.
package mult_pkg;

  // Width of the array multiplier output p[7:0].
  localparam int PROD_W = 8;

  // IDLE: no beats yet. ACCUM: partial frame. HOLD: result presented.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } macc_state_t;

endpackage : mult_pkg

// File: rtl/accum_sat_adder.sv
// Accumulator adder for mult_accum_stage.
// Adds an unsigned product to the running sum in ACC_W+1 bits. The carry into
// bit ACC_W is reported as ovf.
// Build option: define ACC_SAT_EN to clamp the sum to 2^ACC_W-1 on overflow.
// Otherwise the sum wraps modulo 2^ACC_W.
module accum_sat_adder #(
  parameter int PROD_W = mult_pkg::PROD_W,
  parameter int ACC_W  = 10
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] full_sum;

  // One extra bit so the carry out of the accumulator is visible.
  assign full_sum = {1'b0, acc} + (ACC_W + 1)'(prod);
  assign ovf      = full_sum[ACC_W];

`ifdef ACC_SAT_EN
  // Clamp to all-ones. Once clamped, any later non-zero product overflows
  // again, so the sum stays pinned for the rest of the frame.
  assign sum = ovf ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
  // Wrap modulo 2^ACC_W. The sticky flag in the parent records the wrap.
  assign sum = full_sum[ACC_W-1:0];
`endif

endmodule : accum_sat_adder

// File: rtl/mult_accum_stage.sv
// mult_accum_stage: sums a frame of up to N_TERMS multiplier products and
// presents the frame sum, term count and overflow flag over valid/ready.
// Build option: ACC_SAT_EN selects clamp-on-overflow in accum_sat_adder.
// When ACC_SAT_EN is not defined, the accumulator wraps.
module mult_accum_stage #(
  parameter int PROD_W  = mult_pkg::PROD_W,
  parameter int ACC_W   = 10,
  parameter int N_TERMS = 4,
  localparam int CNT_W  = $clog2(N_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  import mult_pkg::*;

  macc_state_t      state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic             accept;
  logic             out_fire;
  logic [ACC_W-1:0] add_base;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] count_next;
  logic             closing;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // The first beat of a frame starts from zero, so it cannot overflow.
  assign add_base   = (state == IDLE) ? '0 : acc;
  assign count_next = (state == IDLE) ? CNT_W'(1) : count + CNT_W'(1);
  assign closing    = in_last || (count_next == CNT_W'(N_TERMS));

  accum_sat_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc  (add_base),
    .prod (in_prod),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  // The result fields read zero whenever no frame result is presented.
  assign out_acc   = out_valid ? acc   : '0;
  assign out_count = out_valid ? count : '0;
  assign out_ovf   = out_valid & ovf;

  // Frame FSM, accumulator, term counter and sticky overflow.
  // flush takes priority over both handshakes.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc   <= add_sum;
            count <= count_next;
            ovf   <= ovf | add_ovf;
            state <= closing ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          // Only the output handshake happens here. in_ready is low in HOLD,
          // so there is a one-cycle bubble before the next beat.
          if (out_fire) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : mult_accum_stage
